// File: rtl/trig_recovery_pkg.sv
// ---------------------------------------------------------------------------
// trig_recovery_pkg
// Shared definitions for the trigger-watchdog recovery sequencer:
//   - FSM state encodings (visible on the 'state' status port)
//   - datapath widths for the phase timer and the retry/recovery counters
//   - saturating increment used by the total-recovery counter
// ---------------------------------------------------------------------------
package trig_recovery_pkg;

    localparam int unsigned TIMER_W = 32;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR_WD  = 3'd1,
        ST_ARMED     = 3'd2,
        ST_RST_PULSE = 3'd3,
        ST_HOLDOFF   = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/trig_recovery_ctrl_timer.sv
// ---------------------------------------------------------------------------
// trig_recovery_timer
// Phase timer: a down-counter that is loaded with (cycles-1) when a phase
// starts and reports done while it holds zero. A phase loaded with N-1 thus
// lasts exactly N cycles.
// Ports:
//   clk_i      - system clock
//   rst_i      - asynchronous active-high reset (count cleared to 0)
//   load_i     - load load_val_i this cycle (takes priority over counting)
//   load_val_i - value to load
//   done_o     - count is zero
// ---------------------------------------------------------------------------
module trig_recovery_timer
    import trig_recovery_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               done_o
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/trig_recovery_ctrl.sv
// ---------------------------------------------------------------------------
// trig_recovery_ctrl
// Recovery sequencer for the trigger watchdog. Clears/arms the watchdog,
// and on each timeout issues a timed downstream reset pulse, waits a holdoff
// period, then re-arms. After MAX_RETRY consecutive recoveries without a
// trigger it latches a fault until software clears it.
// Ports:
//   sys_clk_i   - 50 MHz system clock
//   reset       - asynchronous active-high reset
//   enable      - level; low forces IDLE (counters and fault kept)
//   UsrClear    - clears fault and counters, restarts from CLEAR_WD/IDLE
//   wd_timeout  - watchdog timeout (latched level from the watchdog)
//   trig_ok     - single-cycle trigger pulse, resets the retry count
//   wd_clear    - watchdog clear, high for the whole CLEAR_WD phase
//   sys_rst     - downstream reset, high for the whole RST_PULSE phase
//   fault       - latched give-up flag
//   state       - current FSM state encoding
//   retry_cnt   - consecutive recoveries without a trigger
//   recover_cnt - total recovery pulses issued (saturating)
// ---------------------------------------------------------------------------
module trig_recovery_ctrl
    import trig_recovery_pkg::*;
#(
    parameter int unsigned CLR_CYC       = 4,
    parameter int unsigned RST_PULSE_CYC = 50,
    parameter int unsigned HOLDOFF_CYC   = 50000000,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic               sys_clk_i,
    input  logic               reset,
    input  logic               enable,
    input  logic               UsrClear,
    input  logic               wd_timeout,
    input  logic               trig_ok,
    output logic               wd_clear,
    output logic               sys_rst,
    output logic               fault,
    output logic [2:0]         state,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [CNT_W-1:0]   recover_cnt
);

    state_e             state_q, state_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [CNT_W-1:0]   recover_q, recover_d;
    logic               fault_q, fault_d;
    logic               wd_clear_q, sys_rst_q;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_done;

    // Next-state / counter logic. Priority: UsrClear > enable=0 > FSM.
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        recover_d = recover_q;
        fault_d   = fault_q;
        if (UsrClear) begin
            fault_d   = 1'b0;
            retry_d   = '0;
            recover_d = '0;
            state_d   = enable ? ST_CLEAR_WD : ST_IDLE;
        end else if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = fault_q ? ST_FAULT : ST_CLEAR_WD;
                end
                ST_CLEAR_WD: begin
                    if (tmr_done) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    // A latched timeout beats a same-cycle trigger.
                    if (wd_timeout) begin
                        if (retry_q < RETRY_W'(MAX_RETRY)) begin
                            retry_d   = retry_q + RETRY_W'(1);
                            recover_d = sat_inc(recover_q);
                            state_d   = ST_RST_PULSE;
                        end else begin
                            fault_d = 1'b1;
                            state_d = ST_FAULT;
                        end
                    end else if (trig_ok) begin
                        retry_d = '0;
                    end
                end
                ST_RST_PULSE: begin
                    if (tmr_done) state_d = ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (tmr_done) state_d = ST_CLEAR_WD;
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Timer restarts on every phase entry; a UsrClear restart counts as one.
    always_comb begin
        tmr_load = UsrClear || (state_d != state_q);
        case (state_d)
            ST_CLEAR_WD:  tmr_val = TIMER_W'(CLR_CYC - 1);
            ST_RST_PULSE: tmr_val = TIMER_W'(RST_PULSE_CYC - 1);
            ST_HOLDOFF:   tmr_val = TIMER_W'(HOLDOFF_CYC - 1);
            default:      tmr_val = '0;
        endcase
    end

    trig_recovery_timer u_timer (
        .clk_i      (sys_clk_i),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge sys_clk_i or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            retry_q    <= '0;
            recover_q  <= '0;
            fault_q    <= 1'b0;
            wd_clear_q <= 1'b0;
            sys_rst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            recover_q  <= recover_d;
            fault_q    <= fault_d;
            wd_clear_q <= (state_d == ST_CLEAR_WD);
            sys_rst_q  <= (state_d == ST_RST_PULSE);
        end
    end

    assign wd_clear    = wd_clear_q;
    assign sys_rst     = sys_rst_q;
    assign fault       = fault_q;
    assign state       = state_q;
    assign retry_cnt   = retry_q;
    assign recover_cnt = recover_q;

endmodule
